hazard_stall_unit: RTL and testbench

- Pipeline control block that decides when the front end must hold, bubble or flush.
- Sits in ID beside the operand-bypass logic. It covers the hazards bypassing cannot resolve: load-use, data-memory busy, taken-branch squash and halt.
- Drives the PC and IF/ID write enables and the ID/EX bubble/flush controls. Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_pkg.sv | 32 +++
 rtl/hazard_stall_unit_src_use_decode.sv | 29 ++
 rtl/hazard_stall_unit.sv | 115 +++++++++++
 tb/tb_hazard_stall_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the hazard/stall control slice: opcode values,
// controller state encodings and instruction field positions. Imported by
// hazard_stall_unit, src_use_decode and the operand-bypass block.
package hazard_stall_unit_pkg;

  // 5-bit primary opcodes
  localparam logic [4:0] OP_NOP     = 5'h00;
  localparam logic [4:0] OP_LD      = 5'h01;
  localparam logic [4:0] OP_ST      = 5'h02;
  localparam logic [4:0] OP_ALU_RR  = 5'h03;
  localparam logic [4:0] OP_ALU_IMM = 5'h04;
  localparam logic [4:0] OP_BR      = 5'h05;
  localparam logic [4:0] OP_JR      = 5'h06;
  localparam logic [4:0] OP_HALT    = 5'h1F;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 5;

  // Stall controller states
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FREEZE     = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_stall_unit_src_use_decode.sv
// src_use_decode: tells which register source fields an opcode actually reads.
// Fields that hold immediates or are unused report 0 so they never produce a
// false dependency hit.
//   i_opcode   : instruction opcode [4:0]
//   o_uses_rs  : Rs field [10:8] is a register source
//   o_uses_rt  : Rt field [7:5] is a register source
module src_use_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_uses_rs,
  output logic       o_uses_rt
);

  always_comb begin
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    unique case (i_opcode)
      OP_LD:      o_uses_rs = 1'b1;                 // base address
      OP_ST:      begin o_uses_rs = 1'b1; o_uses_rt = 1'b1; end // base + store data
      OP_ALU_RR:  begin o_uses_rs = 1'b1; o_uses_rt = 1'b1; end
      OP_ALU_IMM: o_uses_rs = 1'b1;                 // [7:5] is immediate
      OP_BR:      begin o_uses_rs = 1'b1; o_uses_rt = 1'b1; end // compare operands
      OP_JR:      o_uses_rs = 1'b1;
      default:    ;                                 // NOP, HALT, undefined
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage control for hazards bypassing cannot cover
// (load-use, data-memory busy, taken-branch squash, halt). Drives PC / IF/ID
// write enables, ID/EX bubble and flush controls, and a saturating counter of
// stall cycles.
//   clk, rst         : clock, synchronous active-high reset
//   ifid_Instr       : instruction in ID (opcode [15:11], Rs [10:8], Rt [7:5])
//   ifid_Valid       : ID holds a real instruction
//   idex_MemRead     : EX instruction is a load
//   idex_RegWriteEn  : EX instruction writes the register file
//   idex_RegD        : EX destination register
//   mem_Stall        : data memory busy
//   branch_taken     : branch/jump resolved taken in EX
//   halt_dec         : ID instruction is HALT
//   pc_WriteEn, ifid_WriteEn, idex_Bubble, ifid_Flush, idex_Flush,
//   pipe_Freeze, halted : Mealy control outputs
//   stall_count      : cycles with pc_WriteEn=0 outside HALTED (saturating)
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ifid_Instr,
  input  logic             ifid_Valid,
  input  logic             idex_MemRead,
  input  logic             idex_RegWriteEn,
  input  logic [2:0]       idex_RegD,
  input  logic             mem_Stall,
  input  logic             branch_taken,
  input  logic             halt_dec,
  output logic             pc_WriteEn,
  output logic             ifid_WriteEn,
  output logic             idex_Bubble,
  output logic             ifid_Flush,
  output logic             idex_Flush,
  output logic             pipe_Freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_uses_rs;
  logic             w_uses_rt;
  logic             w_load_use;
  logic             w_unused_lo;

  // Low instruction bits (destination / immediate) play no part in hazards.
  assign w_unused_lo = ^ifid_Instr[4:0];

  src_use_decode u_src_use_decode (
    .i_opcode  (ifid_Instr[OPC_HI:OPC_LO]),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt)
  );

  // All eight registers compare; R0 is an ordinary register here.
  assign w_load_use = ifid_Valid & idex_MemRead & idex_RegWriteEn &
                      ((w_uses_rs & (idex_RegD == ifid_Instr[RS_HI:RS_LO])) |
                       (w_uses_rt & (idex_RegD == ifid_Instr[RT_HI:RT_LO])));

  always_comb begin
    w_state_nxt  = ST_RUN;
    pc_WriteEn   = 1'b1;
    ifid_WriteEn = 1'b1;
    idex_Bubble  = 1'b0;
    ifid_Flush   = 1'b0;
    idex_Flush   = 1'b0;
    pipe_Freeze  = 1'b0;
    halted       = 1'b0;
    if (r_state == ST_HALTED) begin
      w_state_nxt  = ST_HALTED;
      halted       = 1'b1;
      pc_WriteEn   = 1'b0;
      ifid_WriteEn = 1'b0;
      idex_Bubble  = 1'b1;
    end else if (mem_Stall) begin
      w_state_nxt  = ST_FREEZE;
      pipe_Freeze  = 1'b1;
      pc_WriteEn   = 1'b0;
      ifid_WriteEn = 1'b0;
    end else if (branch_taken) begin
      // ID instruction is squashed, so its load-use or halt is irrelevant.
      ifid_Flush   = 1'b1;
      idex_Flush   = 1'b1;
    end else if (w_load_use && (r_state != ST_LOAD_STALL)) begin
      // In LOAD_STALL the load has reached MEM and bypass covers it.
      w_state_nxt  = ST_LOAD_STALL;
      pc_WriteEn   = 1'b0;
      ifid_WriteEn = 1'b0;
      idex_Bubble  = 1'b1;
    end else if (halt_dec) begin
      // HALT itself proceeds into EX; only fetch stops.
      w_state_nxt  = ST_HALTED;
      pc_WriteEn   = 1'b0;
      ifid_WriteEn = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!pc_WriteEn && (r_state != ST_HALTED) && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ifid_Instr;
  logic        ifid_Valid;
  logic        idex_MemRead;
  logic        idex_RegWriteEn;
  logic [2:0]  idex_RegD;
  logic        mem_Stall;
  logic        branch_taken;
  logic        halt_dec;
  logic        pc_WriteEn;
  logic        ifid_WriteEn;
  logic        idex_Bubble;
  logic        ifid_Flush;
  logic        idex_Flush;
  logic        pipe_Freeze;
  logic        halted;
  logic [3:0]  stall_count;

  int n_total = 0;
  int n_pass  = 0;

  hazard_stall_unit #(.CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifid_Instr      (ifid_Instr),
    .ifid_Valid      (ifid_Valid),
    .idex_MemRead    (idex_MemRead),
    .idex_RegWriteEn (idex_RegWriteEn),
    .idex_RegD       (idex_RegD),
    .mem_Stall       (mem_Stall),
    .branch_taken    (branch_taken),
    .halt_dec        (halt_dec),
    .pc_WriteEn      (pc_WriteEn),
    .ifid_WriteEn    (ifid_WriteEn),
    .idex_Bubble     (idex_Bubble),
    .ifid_Flush      (ifid_Flush),
    .idex_Flush      (idex_Flush),
    .pipe_Freeze     (pipe_Freeze),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [4:0] lo);
    return {op, rs, rt, lo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // pc, ifid_we, bubble, ifid_flush, idex_flush, freeze, halted
  task automatic chk_out(input string tag, input logic [6:0] exp);
    chk({tag, ".ctl"}, {9'd0, pc_WriteEn, ifid_WriteEn, idex_Bubble, ifid_Flush,
                        idex_Flush, pipe_Freeze, halted}, {9'd0, exp});
  endtask

  task automatic idle();
    ifid_Instr = mk(OP_NOP, 3'd0, 3'd0, 5'd0);
    ifid_Valid = 1'b0; idex_MemRead = 1'b0; idex_RegWriteEn = 1'b0;
    idex_RegD = 3'd0; mem_Stall = 1'b0; branch_taken = 1'b0; halt_dec = 1'b0;
  endtask

  // Load R3 in EX, given instruction in ID
  task automatic ld3(input logic [15:0] instr);
    idle();
    ifid_Instr = instr; ifid_Valid = 1'b1;
    idex_MemRead = 1'b1; idex_RegWriteEn = 1'b1; idex_RegD = 3'd3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  localparam logic [6:0] RUNV  = 7'b1100000;
  localparam logic [6:0] LUSE  = 7'b0010000;
  localparam logic [6:0] BRV   = 7'b1101100;
  localparam logic [6:0] FRZ   = 7'b0000010;
  localparam logic [6:0] HLTE  = 7'b0000000;
  localparam logic [6:0] HLTD  = 7'b0010001;

  initial begin
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("reset.count", 16'(stall_count), 16'd0);
    chk_out("reset.run", RUNV);

    // Load-use through Rs
    ld3(mk(OP_ALU_RR, 3'd3, 3'd2, 5'd1)); #1;
    chk_out("lu_rs", LUSE);
    tick(); #1;  // LOAD_STALL with same inputs: no re-evaluation
    chk_out("lu_stall_cycle", RUNV);
    chk("lu.count", 16'(stall_count), 16'd1);
    tick(); idle(); #1;
    chk_out("lu.back_run", RUNV);

    // Immediate field equals RegD: no stall
    ld3(mk(OP_ALU_IMM, 3'd2, 3'd3, 5'd0)); #1;
    chk_out("imm_false_hit", RUNV);
    // Rt hit
    ld3(mk(OP_ALU_RR, 3'd2, 3'd3, 5'd1)); #1;
    chk_out("lu_rt", LUSE);
    tick(); idle(); #1;
    chk("lu_rt.count", 16'(stall_count), 16'd2);
    tick();
    // R0 compares like any register
    ld3(mk(OP_ALU_IMM, 3'd0, 3'd5, 5'd0)); idex_RegD = 3'd0; #1;
    chk_out("lu_r0", LUSE);
    tick(); idle(); tick();
    chk("lu_r0.count", 16'(stall_count), 16'd3);
    // Non-writing EX instruction, invalid ID, NOP with matching bits: no stall
    ld3(mk(OP_ALU_RR, 3'd3, 3'd3, 5'd0)); idex_RegWriteEn = 1'b0; #1;
    chk_out("no_regwrite", RUNV);
    ld3(mk(OP_ALU_RR, 3'd3, 3'd3, 5'd0)); ifid_Valid = 1'b0; #1;
    chk_out("invalid_id", RUNV);
    ld3(mk(OP_NOP, 3'd3, 3'd3, 5'd0)); #1;
    chk_out("nop_no_use", RUNV);

    // Branch beats load-use; state stays RUN so load-use fires next cycle
    ld3(mk(OP_ALU_RR, 3'd3, 3'd2, 5'd1)); branch_taken = 1'b1; #1;
    chk_out("br_over_lu", BRV);
    tick(); branch_taken = 1'b0; #1;
    chk_out("lu_after_br", LUSE);
    tick(); idle(); #1;
    chk("br.count", 16'(stall_count), 16'd4);
    // Branch beats halt
    halt_dec = 1'b1; branch_taken = 1'b1; #1;
    chk_out("br_over_halt", BRV);
    tick(); idle();

    // Memory busy 3 cycles, with branch and load-use pending underneath
    for (int i = 0; i < 3; i++) begin
      ld3(mk(OP_ALU_RR, 3'd3, 3'd2, 5'd1)); mem_Stall = 1'b1; branch_taken = 1'b1; #1;
      chk_out($sformatf("freeze%0d", i), FRZ);
      tick();
    end
    ld3(mk(OP_ALU_RR, 3'd3, 3'd2, 5'd1)); #1;  // FREEZE exit sees load-use
    chk("freeze.count", 16'(stall_count), 16'd7);
    chk_out("freeze_exit_lu", LUSE);
    tick(); idle(); #1;
    chk("freeze_lu.count", 16'(stall_count), 16'd8);
    chk_out("freeze_lu.ls", RUNV);
    tick();

    // Saturation: 10 more stall cycles from 8
    mem_Stall = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("sat.count15", 16'(stall_count), 16'd15);
    for (int i = 0; i < 3; i++) tick();
    chk("sat.hold", 16'(stall_count), 16'd15);
    // Reset during FREEZE with inputs still asserting stall
    rst = 1'b1; tick();
    rst = 1'b0; idle(); #1;
    chk("rst_freeze.count", 16'(stall_count), 16'd0);
    chk_out("rst_freeze.run", RUNV);

    // Halt
    halt_dec = 1'b1; #1;
    chk_out("halt_enter", HLTE);
    tick(); idle(); #1;
    chk("halt.count", 16'(stall_count), 16'd1);
    for (int i = 0; i < 20; i++) begin
      ifid_Instr = 16'($urandom); ifid_Valid = 1'($urandom);
      idex_MemRead = 1'($urandom); idex_RegWriteEn = 1'($urandom);
      idex_RegD = 3'($urandom); mem_Stall = 1'($urandom);
      branch_taken = 1'($urandom); halt_dec = 1'($urandom); #1;
      chk_out($sformatf("halted%0d", i), HLTD);
      tick();
    end
    chk("halt.count_frozen", 16'(stall_count), 16'd1);
    rst = 1'b1; tick(); rst = 1'b0; idle(); #1;
    chk_out("halt_rst", RUNV);
    chk("halt_rst.count", 16'(stall_count), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
